// File: rtl/adc_pkg.sv
// Shared constants, register layout and helpers for the ADC sample store.
package adc_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_CTRL      = 3'd2;
    localparam logic [2:0] ADDR_WATERMARK = 3'd3;
    localparam logic [2:0] ADDR_CHMASK    = 3'd4;

    localparam int unsigned ST_EMPTY    = 16;
    localparam int unsigned ST_FULL     = 17;
    localparam int unsigned ST_OVERFLOW = 18;
    localparam int unsigned ST_WM_HIT   = 19;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_RING   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_FLUSH  = 3;

    localparam int unsigned DATA_VALID_BIT = 31;
    localparam int unsigned DATA_CH_LSB    = 16;

    typedef struct packed {
        logic irq_en;
        logic ring;
        logic enable;
    } ctrl_t;

    function automatic int unsigned clog2_depth(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(depth)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adc_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module adc_sample_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WORD_W = 17
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int unsigned ENTRIES = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [0:ENTRIES-1];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_sample_store.sv
// Tagged ADC sample FIFO with stop/ring modes, channel mask, watermark irq
// and an Avalon-MM CSR slave with read latency 1.
module adc_sample_store
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CH_W   = 5,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clock_clk,
    input  logic              reset_sink_reset_n,
    input  logic              smp_valid,
    input  logic [CH_W-1:0]   smp_channel,
    input  logic [DATA_W-1:0] smp_data,
    input  logic [2:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq
);

    localparam int unsigned AW = clog2_depth(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = CH_W + DATA_W;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [15:0]   wm_q, wm_d;
    logic [31:0]   chmask_q, chmask_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic          fwd_q, fwd_d;
    logic [EW-1:0] fwd_data_q, fwd_data_d;

    logic          ram_we;
    logic [EW-1:0] ram_rdata;
    logic [EW-1:0] head;
    logic [EW-1:0] entry_in;
    logic [4:0]    ch_idx;
    logic          empty, full, wm_hit;
    logic          cap, pop, flush, ovf_set, ovf_clr;

    assign ch_idx   = 5'(smp_channel);
    assign entry_in = {smp_channel, smp_data};
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign wm_hit   = (wm_q != 16'd0) && (16'(count_q) >= wm_q);
    assign head     = fwd_q ? fwd_data_q : ram_rdata;

    assign cap   = smp_valid && ctrl_q.enable && chmask_q[ch_idx];
    assign pop   = csr_read && (csr_address == ADDR_DATA) && !empty;
    assign flush = csr_write && (csr_address == ADDR_CTRL) && csr_writedata[CTRL_FLUSH];

    // Pointer/count update; a flush overrides any push or pop in its cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ram_we   = 1'b0;
        ovf_set  = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (cap) begin
                if (!full || pop) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (!pop) count_d = count_q + 1'b1;
                end else if (ctrl_q.ring) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    ovf_set  = 1'b1;
                end else begin
                    ovf_set  = 1'b1;
                end
            end else if (pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // The RAM reads next_rd_ptr; forward a same-cycle write to that slot.
    always_comb begin
        fwd_d      = ram_we && (wr_ptr_q == rd_ptr_d);
        fwd_data_d = entry_in;
    end

    // CSR writes.
    always_comb begin
        ctrl_d   = ctrl_q;
        wm_d     = wm_q;
        chmask_d = chmask_q;
        ovf_clr  = 1'b0;
        if (csr_write) begin
            case (csr_address)
                ADDR_STATUS:    ovf_clr = csr_writedata[ST_OVERFLOW];
                ADDR_CTRL: begin
                    ctrl_d.enable = csr_writedata[CTRL_ENABLE];
                    ctrl_d.ring   = csr_writedata[CTRL_RING];
                    ctrl_d.irq_en = csr_writedata[CTRL_IRQ_EN];
                end
                ADDR_WATERMARK: wm_d     = csr_writedata[15:0];
                ADDR_CHMASK:    chmask_d = csr_writedata;
                default: ;
            endcase
        end
        ovf_d = (ovf_q && !ovf_clr) || ovf_set;
        irq_d = ctrl_q.irq_en && wm_hit;
    end

    // CSR reads return pre-update state; readdata holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (csr_read) begin
            rdata_d = '0;
            case (csr_address)
                ADDR_DATA: begin
                    if (!empty) begin
                        rdata_d[DATA_VALID_BIT]        = 1'b1;
                        rdata_d[DATA_CH_LSB +: CH_W]   = head[DATA_W +: CH_W];
                        rdata_d[0 +: DATA_W]           = head[DATA_W-1:0];
                    end
                end
                ADDR_STATUS: begin
                    rdata_d[15:0]        = 16'(count_q);
                    rdata_d[ST_EMPTY]    = empty;
                    rdata_d[ST_FULL]     = full;
                    rdata_d[ST_OVERFLOW] = ovf_q;
                    rdata_d[ST_WM_HIT]   = wm_hit;
                end
                ADDR_CTRL: begin
                    rdata_d[CTRL_ENABLE] = ctrl_q.enable;
                    rdata_d[CTRL_RING]   = ctrl_q.ring;
                    rdata_d[CTRL_IRQ_EN] = ctrl_q.irq_en;
                end
                ADDR_WATERMARK: rdata_d[15:0] = wm_q;
                ADDR_CHMASK:    rdata_d       = chmask_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ctrl_q     <= '0;
            wm_q       <= 16'(DEPTH / 2);
            chmask_q   <= '1;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ctrl_q     <= ctrl_d;
            wm_q       <= wm_d;
            chmask_q   <= chmask_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    adc_sample_ram #(
        .ADDR_W (AW),
        .WORD_W (EW)
    ) u_ram (
        .clk     (clock_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (entry_in),
        .rd_addr (rd_ptr_d),
        .rd_data (ram_rdata)
    );

    assign csr_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_adc_sample_store.sv
// Bench for adc_sample_store: directed vector table, multi-cycle sequences,
// then random traffic against a queue-based reference model.
module tb_adc_sample_store;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CH_W   = 5;
    localparam int unsigned DEPTH  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smp_valid;
    logic [4:0]  smp_channel;
    logic [11:0] smp_data;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adc_sample_store #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock_clk          (clk),
        .reset_sink_reset_n (rst_n),
        .smp_valid          (smp_valid),
        .smp_channel        (smp_channel),
        .smp_data           (smp_data),
        .csr_address        (csr_address),
        .csr_read           (csr_read),
        .csr_write          (csr_write),
        .csr_writedata      (csr_writedata),
        .csr_readdata       (csr_readdata),
        .irq                (irq)
    );

    typedef struct packed {
        logic        v;
        logic [4:0]  ch;
        logic [11:0] d;
        logic        rd;
        logic        wr;
        logic [2:0]  a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [16:0] mq[$];
    logic        m_en, m_ring, m_irq_en, m_ovf;
    logic [15:0] m_wm;
    logic [31:0] m_mask;
    logic [31:0] exp_rdata;
    logic        exp_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] ch, input logic [11:0] d,
                         input logic rd, input logic wr, input logic [2:0] a,
                         input logic [31:0] wd);
        smp_valid     = v;
        smp_channel   = ch;
        smp_data      = d;
        csr_read      = rd;
        csr_write     = wr;
        csr_address   = a;
        csr_writedata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 12'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic push(input logic [4:0] ch, input logic [11:0] d);
        drive(1'b1, ch, d, 1'b0, 1'b0, 3'd0, 32'd0);
        step();
        idle();
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] wd);
        drive(1'b0, 5'd0, 12'd0, 1'b0, 1'b1, a, wd);
        step();
        idle();
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] data);
        drive(1'b0, 5'd0, 12'd0, 1'b1, 1'b0, a, 32'd0);
        step();
        data = csr_readdata;
        idle();
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] ch, input logic [11:0] d,
                                input logic rd, input logic wr, input logic [2:0] a,
                                input logic [31:0] wd, input logic [31:0] exp_rd);
        vec_t t;
        t.v = v; t.ch = ch; t.d = d; t.rd = rd; t.wr = wr; t.a = a; t.wd = wd;
        t.chk_rd = rd; t.exp_rd = exp_rd; t.exp_irq = 1'b0;
        return t;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_ring = 0; m_irq_en = 0; m_ovf = 0;
        m_wm = 16'(DEPTH / 2);
        m_mask = '1;
        exp_rdata = '0;
        exp_irq = 0;
    endtask

    // Behavioural model of one cycle: reads see pre-cycle state.
    task automatic model_step(input logic v, input logic [4:0] ch, input logic [11:0] d,
                              input logic rd, input logic wr, input logic [2:0] a,
                              input logic [31:0] wd);
        int          sz;
        logic        full, hit, flush, pop, cap, set;
        logic [15:0] cnt;
        sz    = mq.size();
        full  = (sz == DEPTH);
        cnt   = 16'(sz);
        hit   = (m_wm != 0) && (cnt >= m_wm);
        flush = wr && (a == 3'd2) && wd[3];
        pop   = rd && (a == 3'd0) && (sz > 0);
        cap   = v && m_en && m_mask[ch];
        set   = 0;
        if (rd) begin
            case (a)
                3'd0: exp_rdata = pop ? {1'b1, 10'd0, mq[0][16:12], 4'd0, mq[0][11:0]} : 32'd0;
                3'd1: exp_rdata = {12'd0, hit, m_ovf, full, (sz == 0), cnt};
                3'd2: exp_rdata = {29'd0, m_irq_en, m_ring, m_en};
                3'd3: exp_rdata = {16'd0, m_wm};
                3'd4: exp_rdata = m_mask;
                default: exp_rdata = 32'd0;
            endcase
        end
        exp_irq = m_irq_en && hit;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (!full || pop) mq.push_back({ch, d});
                else begin
                    set = 1;
                    if (m_ring) begin
                        void'(mq.pop_front());
                        mq.push_back({ch, d});
                    end
                end
            end
        end
        if (wr && (a == 3'd1) && wd[18]) m_ovf = 0;
        if (set) m_ovf = 1;
        if (wr) begin
            case (a)
                3'd2: begin m_en = wd[0]; m_ring = wd[1]; m_irq_en = wd[2]; end
                3'd3: m_wm = wd[15:0];
                3'd4: m_mask = wd;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [31:0] r;
        int          sz;
        logic        v, rd, wr;
        logic [4:0]  ch;
        logic [11:0] d;
        logic [2:0]  a;
        logic [31:0] wd;
        int          p;

        rst_n = 1'b0;
        idle();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_readdata", csr_readdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);

        // Directed vectors: reset register values, basic push/pop, mask.
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd1, 0, 32'h0001_0000));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd2, 0, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd3, 0, 32'h0000_0020));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd4, 0, 32'hFFFF_FFFF));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd5, 0, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 0,       0, 1, 3'd6, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd6, 0, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 0,       0, 1, 3'd2, 32'h1, 0));
        vecs.push_back(mk(1, 3, 12'h0AB, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(1, 7, 12'hFFF, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd1, 0, 32'h0000_0002));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd0, 0, 32'h8003_00AB));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd0, 0, 32'h8007_0FFF));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd0, 0, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd1, 0, 32'h0001_0000));
        vecs.push_back(mk(0, 0, 0,       0, 1, 3'd4, 32'h1, 0));
        vecs.push_back(mk(1, 1, 12'h555, 0, 0, 3'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd1, 0, 32'h0001_0000));
        vecs.push_back(mk(0, 0, 0,       0, 1, 3'd4, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 3'd2, 0, 32'h0000_0001));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].ch, vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
            step();
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), csr_readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end
        idle();

        // Stop mode overfill.
        for (int i = 0; i < 66; i++) push(5'd0, 12'(i));
        csr_rd(3'd1, r); check("stop_status_full", r, 32'h000E_0040);
        drive(1'b0, 5'd0, 12'd0, 1'b1, 1'b0, 3'd0, 32'd0);
        for (int i = 0; i < 64; i++) begin
            step();
            check($sformatf("stop_pop%0d", i), csr_readdata, 32'h8000_0000 | 32'(i));
        end
        idle();
        csr_rd(3'd1, r); check("stop_status_drained", r, 32'h0005_0000);
        csr_wr(3'd1, 32'h0004_0000);
        csr_rd(3'd1, r); check("ovf_cleared", r, 32'h0001_0000);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 64; i++) push(5'd0, 12'(i));
        drive(1'b1, 5'd2, 12'h123, 1'b1, 1'b0, 3'd0, 32'd0);
        step();
        check("full_pushpop_head", csr_readdata, 32'h8000_0000);
        idle();
        csr_rd(3'd1, r); check("full_pushpop_status", r, 32'h000A_0040);
        drive(1'b0, 5'd0, 12'd0, 1'b1, 1'b0, 3'd0, 32'd0);
        for (int i = 1; i < 64; i++) begin
            step();
            check($sformatf("fpp_pop%0d", i), csr_readdata, 32'h8000_0000 | 32'(i));
        end
        step();
        check("fpp_last", csr_readdata, 32'h8002_0123);
        idle();

        // Ring mode overfill.
        csr_wr(3'd2, 32'h3);
        for (int i = 0; i < 66; i++) push(5'd0, 12'(i));
        csr_rd(3'd1, r); check("ring_status_full", r, 32'h000E_0040);
        drive(1'b0, 5'd0, 12'd0, 1'b1, 1'b0, 3'd0, 32'd0);
        for (int i = 2; i < 66; i++) begin
            step();
            check($sformatf("ring_pop%0d", i), csr_readdata, 32'h8000_0000 | 32'(i));
        end
        idle();
        csr_rd(3'd1, r); check("ring_status_drained", r, 32'h0005_0000);
        csr_wr(3'd1, 32'h0004_0000);

        // Watermark interrupt timing.
        csr_wr(3'd3, 32'd4);
        csr_wr(3'd2, 32'h5);
        for (int i = 0; i < 3; i++) push(5'd1, 12'(i));
        step();
        check("wm_irq_below", 32'(irq), 32'd0);
        push(5'd1, 12'd3);
        check("wm_irq_n1", 32'(irq), 32'd0);
        step();
        check("wm_irq_n2", 32'(irq), 32'd1);
        csr_rd(3'd0, r); check("wm_pop", r, 32'h8001_0000);
        step();
        check("wm_irq_fall", 32'(irq), 32'd0);

        // Flush in the same cycle as a push.
        drive(1'b1, 5'd0, 12'h777, 1'b0, 1'b1, 3'd2, 32'h9);
        step();
        idle();
        csr_rd(3'd1, r); check("flush_status", r, 32'h0001_0000);
        csr_rd(3'd2, r); check("flush_ctrl", r, 32'h0000_0001);

        // Random traffic against the reference model.
        rst_n = 1'b0;
        idle();
        step();
        model_reset();
        check("rand_reset_rdata", csr_readdata, exp_rdata);
        check("rand_reset_irq", 32'(irq), 32'(exp_irq));
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                idle();
                step();
                model_reset();
                check("mid_reset_rdata", csr_readdata, 32'd0);
                check("mid_reset_irq", 32'(irq), 32'd0);
                rst_n = 1'b1;
            end
            case ((i / 300) % 3)
                0: p = 15;
                1: p = 75;
                default: p = 45;
            endcase
            v  = ($urandom % 4) != 0;
            ch = 5'($urandom % 32);
            d  = 12'($urandom);
            wr = ($urandom % 20) == 0;
            wd = $urandom;
            if (wr) begin
                case ($urandom % 5)
                    0: begin a = 3'd1; end
                    1: begin a = 3'd2; wd[0] = ($urandom % 8) != 0; wd[3] = ($urandom % 8) == 0; end
                    2: begin a = 3'd3; wd = 32'($urandom % 70); end
                    3: begin a = 3'd4; if ($urandom % 2 == 0) wd = '1; end
                    default: a = 3'd6;
                endcase
                rd = ($urandom % 2) == 0;
            end else begin
                rd = ($urandom % 100) < p;
                a  = (($urandom % 4) == 0) ? 3'($urandom % 8) : 3'd0;
            end
            drive(v, ch, d, rd, wr, a, wd);
            model_step(v, ch, d, rd, wr, a, wd);
            step();
            check($sformatf("rand%0d_rdata", i), csr_readdata, exp_rdata);
            check($sformatf("rand%0d_irq", i), 32'(irq), 32'(exp_irq));
        end
        idle();
        sz = mq.size();
        csr_rd(3'd1, r);
        check("rand_final_count", 32'(r[15:0]), 32'(sz));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_store.md
# adc_sample_store

Parametrised successor to the ADC sample-store CSR block. Captures tagged conversion results from the ADC sequencer output stream into a power-of-two FIFO. The FIFO supports stop-when-full or ring (overwrite-oldest) mode, a per-channel capture mask, a programmable watermark interrupt and a sticky overflow flag. It sits between the ADC sequencer and the system interconnect and is read by the CPU through an Avalon-MM slave with fixed read latency 1.

## Interface
- DATA_W, 12, sample width in bits; valid range 1..16.
- CH_W, 5, channel-tag width in bits; valid range 1..5.
- DEPTH, 64, FIFO entries; must be a power of two, 2..32768.
- clock_clk  in  1  single clock for all logic.
- reset_sink_reset_n  in  1  asynchronous, active-low reset.
- smp_valid  in  1  one sample is presented this cycle. There is no backpressure.
- smp_channel  in  CH_W  channel tag of the sample.
- smp_data  in  DATA_W  conversion result.
- csr_address  in  3  word address.
- csr_read  in  1  read strobe.
- csr_write  in  1  write strobe.
- csr_writedata  in  32  write data.
- csr_readdata  out  32  read data. Registered; valid the cycle after csr_read.
- irq  out  1  level interrupt. Registered.

## Operation
- Register map (word address):
  - 0 DATA, RO, read pops one entry. Fields: [31] valid, [16+CH_W-1:16] channel, [DATA_W-1:0] data.
  - 1 STATUS. Fields: [15:0] count, [16] empty, [17] full, [18] overflow (write 1 to clear), [19] wm_hit.
  - 2 CTRL. Fields: [0] enable, [1] ring, [2] irq_en, [3] flush (write-only, self-clearing, reads 0).
  - 3 WATERMARK, [15:0].
  - 4 CHMASK, [31:0]; bit n enables capture of channel n.
  - 5–7 read 0; writes to them are ignored.
- Reset values:
  - csr_readdata=0, irq=0.
  - count=0, pointers 0, overflow=0.
  - CTRL=0 (disabled, stop mode).
  - WATERMARK=DEPTH/2.
  - CHMASK=all ones.
- Capture condition: smp_valid & enable & CHMASK[smp_channel]. Samples that fail this are ignored and do not set overflow.
- Push when not full: write {channel,data} at wr_ptr, then wr_ptr++ and count++.
- Push when full, stop mode: sample dropped; overflow set.
- Push when full, ring mode: sample written at wr_ptr, both wr_ptr and rd_ptr advance, count stays DEPTH; overflow set.
- DATA read when not empty: returns the head entry with valid=1, then rd_ptr++ and count--.
- DATA read when empty: returns 0 (valid=0); no state change.
- Push and pop in the same cycle: both take effect and count is unchanged. This includes the full case in either mode: the push is accepted and nothing is dropped; overflow is not set.
- Flush: write CTRL with bit 3=1. Clears pointers and count at the end of that cycle. A push in the same cycle is discarded without setting overflow. The other CTRL bits in that write still take effect.
- Overflow: a set event and a write-1-to-clear in the same cycle leave overflow at 1.
- wm_hit = (WATERMARK != 0) & (count >= WATERMARK).
- irq is registered: irq <= irq_en & wm_hit.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, zero-extended into STATUS.
- Changing ring or CHMASK mid-capture takes effect on the next sample; stored data is untouched.
- Asserting reset mid-operation restores all reset values immediately. RAM contents are not cleared but are unreachable until rewritten.

## Timing
- Sample to visible: smp_valid in cycle N updates count and STATUS in cycle N+1, and irq in cycle N+2.
- Read latency: csr_read in cycle N gives csr_readdata in cycle N+1. csr_readdata holds its value until the next read.
- Back-to-back DATA reads on consecutive cycles return consecutive entries. The head must be correct the cycle after a pop, so the RAM read address is computed from next_rd_ptr.
- STATUS read in cycle N reflects state before any cycle-N push or pop.
- csr_read and csr_write asserted together: both are performed.
- Write effects are visible to a read issued on the following cycle.

## Structure
- Package adc_pkg:
  - register address constants;
  - STATUS and CTRL bit indices;
  - helper function clog2_depth.
- Sub-module adc_sample_ram: simple dual-port, one write port, one synchronous read port, DEPTH x (CH_W+DATA_W). Inferable as block RAM.
- The top level contains the pointer/count logic, the CSR decode and the irq register.

## Test plan
- Reset, then read all registers: STATUS=0x00010000, CTRL=0, WATERMARK=32, CHMASK=0xFFFFFFFF, irq=0.
- Enable; push ch3/0x0AB then ch7/0xFFF; read DATA twice, then a third time: 0x800300AB, 0x80070FFF, then 0x00000000. STATUS count=0, empty=1.
- Stop mode, DEPTH=64: push 66 samples with data 0..65. Result: full=1, overflow=1; the reads return data 0..63. Write STATUS 0x40000 clears overflow.
- Ring mode: push 66 samples with data 0..65. The first read returns data 2, the last returns data 65; overflow=1.
- WATERMARK=4, irq_en=1: irq rises two cycles after the 4th push. After one DATA read, irq falls within two cycles.
- Each of the following is one sample and the response it must produce:
  - CHMASK=0x1 with a ch1 push: ignored; count=0 and overflow=0.
  - Full FIFO with simultaneous push and pop: count stays 64 and overflow=0.
  - Flush in the same cycle as a push: count=0 and overflow=0.
